// File: rtl/lvds_pkg.sv
// Shared constants and lane packing for the FPD-Link style LVDS transmitter.
package lvds_pkg;

  // Default panel timing (pixels / lines)
  localparam int unsigned H_ACTIVE_DEF = 1024;
  localparam int unsigned H_FP_DEF     = 40;
  localparam int unsigned H_SYNC_DEF   = 128;
  localparam int unsigned H_BP_DEF     = 152;
  localparam int unsigned V_ACTIVE_DEF = 600;
  localparam int unsigned V_FP_DEF     = 3;
  localparam int unsigned V_SYNC_DEF   = 6;
  localparam int unsigned V_BP_DEF     = 26;

  // Bits per pixel slot and the clock-lane waveform, MSB sent first
  localparam int unsigned SLOT_LEN    = 7;
  localparam logic [6:0]  CLK_PATTERN = 7'b1100011;

  // One pixel slot worth of serial data, one 7-bit word per lane
  typedef struct packed {
    logic [6:0] lane2;
    logic [6:0] lane1;
    logic [6:0] lane0;
  } lane_word_t;

  // Map 18-bit colour plus controls onto the three data lanes; colour is
  // blanked whenever DE is low so porches and sync always carry zeros.
  function automatic lane_word_t pack_lanes(input logic [23:0] color,
                                            input logic        de,
                                            input logic        hs,
                                            input logic        vs);
    logic [5:0] r;
    logic [5:0] g;
    logic [5:0] b;
    lane_word_t w;
    r = de ? color[23:18] : 6'd0;
    g = de ? color[15:10] : 6'd0;
    b = de ? color[7:2]   : 6'd0;
    w.lane0 = {g[0], r};
    w.lane1 = {b[1:0], g[5:1]};
    w.lane2 = {de, vs, hs, b[5:2]};
    return w;
  endfunction

endpackage

// File: rtl/lvds_serializer.sv
// 7:1 serializer: loads one lane word per slot and shifts the three data
// lanes and the clock lane out MSB-first.
module lvds_serializer
  import lvds_pkg::*;
(
  input  logic       clk_in,
  input  logic       button,
  input  logic       load,
  input  lane_word_t word,
  output logic [2:0] rx,
  output logic       clk_out
);

  lane_word_t data_q, data_d;
  logic [6:0] clk_sr_q, clk_sr_d;

  // Next shift-register contents: reload on the slot boundary, else shift left
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    data_d   = data_q;
    clk_sr_d = clk_sr_q;
    if (load) begin
      data_d   = word;
      clk_sr_d = CLK_PATTERN;
    end else begin
      data_d.lane0 = {data_q.lane0[5:0], 1'b0};
      data_d.lane1 = {data_q.lane1[5:0], 1'b0};
      data_d.lane2 = {data_q.lane2[5:0], 1'b0};
      clk_sr_d     = {clk_sr_q[5:0], 1'b0};
    end
  end

  // Shift registers; cleared in reset so the lanes idle low
  always_ff @(posedge clk_in or negedge button) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!button) begin
      data_q   <= '0;
      clk_sr_q <= '0;
    end else begin
      data_q   <= data_d;
      clk_sr_q <= clk_sr_d;
    end
  end

  // Outputs come straight from flop MSBs: no combinational path from the word
  assign rx      = {data_q.lane2[6], data_q.lane1[6], data_q.lane0[6]};
  assign clk_out = clk_sr_q[6];

endmodule

// File: rtl/lvds_display.sv
// LVDS panel transmitter top: raster counters, sync/DE decode and the
// per-slot hand-off of the sampled pixel to the serializer.
module lvds_display
  import lvds_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned H_FP     = H_FP_DEF,
  parameter int unsigned H_SYNC   = H_SYNC_DEF,
  parameter int unsigned H_BP     = H_BP_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter int unsigned V_FP     = V_FP_DEF,
  parameter int unsigned V_SYNC   = V_SYNC_DEF,
  parameter int unsigned V_BP     = V_BP_DEF,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0
) (
  input  logic        clk_in,
  input  logic        button,
  input  logic [23:0] color,
  output logic [11:0] x,
  output logic [11:0] y,
  output logic [2:0]  rx,
  output logic        clk_out,
  output logic [7:0]  led
);

  localparam logic [11:0] H_LAST   = 12'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [11:0] V_LAST   = 12'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [11:0] H_VIS    = 12'(H_ACTIVE);
  localparam logic [11:0] V_VIS    = 12'(V_ACTIVE);
  localparam logic [11:0] HS_START = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_END   = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] VS_START = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] VS_END   = 12'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [2:0]  PH_LAST  = 3'(SLOT_LEN - 1);

  logic [2:0]  phase_q, phase_d;
  logic [11:0] x_q, x_d;
  logic [11:0] y_q, y_d;
  logic [7:0]  led_q, led_d;
  logic        de, hs, vs, load;
  lane_word_t  word;

  // Raster advance: phase every cycle, x per slot, y per line, led per frame
  always_comb begin
    phase_d = phase_q + 3'd1;
    x_d     = x_q;
    y_d     = y_q;
    led_d   = led_q;
    if (phase_q == PH_LAST) begin
      phase_d = 3'd0;
      if (x_q == H_LAST) begin
        x_d = 12'd0;
        if (y_q == V_LAST) begin
          y_d   = 12'd0;
          led_d = led_q + 8'd1;
        end else begin
          y_d = y_q + 12'd1;
        end
      end else begin
        x_d = x_q + 12'd1;
      end
    end
  end

  // Raster state registers; reset discards any partial pixel
  always_ff @(posedge clk_in or negedge button) begin
    if (!button) begin
      phase_q <= 3'd0;
      x_q     <= 12'd0;
      y_q     <= 12'd0;
      led_q   <= 8'd0;
    end else begin
      phase_q <= phase_d;
      x_q     <= x_d;
      y_q     <= y_d;
      led_q   <= led_d;
    end
  end

  // Control decode for the coordinate currently on x/y
  always_comb begin
    de   = (x_q < H_VIS) && (y_q < V_VIS);
    hs   = HS_POL ^ ~((x_q >= HS_START) && (x_q < HS_END));
    vs   = VS_POL ^ ~((y_q >= VS_START) && (y_q < VS_END));
    word = pack_lanes(color, de, hs, vs);
    load = (phase_q == PH_LAST);
  end

  // Word captured on the last phase of slot N is shifted out during slot N+1
  lvds_serializer u_ser (
    .clk_in  (clk_in),
    .button  (button),
    .load    (load),
    .word    (word),
    .rx      (rx),
    .clk_out (clk_out)
  );

  assign x   = x_q;
  assign y   = y_q;
  assign led = led_q;

endmodule

// File: tb/tb_lvds_display.sv
// Directed bench for lvds_display on a reduced raster (H 8/2/2/2, V 4/1/1/1).
module tb_lvds_display;

  localparam int HT = 14;   // H_TOTAL
  localparam int VT = 7;    // V_TOTAL
  localparam int NV = 14;

  typedef struct {
    int          x;
    int          y;
    logic [23:0] color;
    logic [6:0]  l0;
    logic [6:0]  l1;
    logic [6:0]  l2;
  } vec_t;

  logic        clk_in;
  logic        button;
  logic [23:0] color;
  logic [11:0] x;
  logic [11:0] y;
  logic [2:0]  rx;
  logic        clk_out;
  logic [7:0]  led;

  int   assertions = 0;
  int   failures   = 0;
  vec_t vecs [NV];
  logic [6:0] clk_exp;

  lvds_display #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0)
  ) dut (
    .clk_in  (clk_in),
    .button  (button),
    .color   (color),
    .x       (x),
    .y       (y),
    .rx      (rx),
    .clk_out (clk_out),
    .led     (led)
  );

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertions++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " x"},       32'(x),       32'd0);
    check({tag, " y"},       32'(y),       32'd0);
    check({tag, " rx"},      32'(rx),      32'd0);
    check({tag, " clk_out"}, 32'(clk_out), 32'd0);
    check({tag, " led"},     32'(led),     32'd0);
  endtask

  // Runs from the negedge at which reset was released (k = 0) through k_end.
  // Negedge k sits in slot k/7 at phase k%7.
  task automatic run(input int k_end);
    int s;
    int p;
    logic [6:0] cap0, cap1, cap2;
    cap0 = '0; cap1 = '0; cap2 = '0;
    for (int k = 0; k <= k_end; k++) begin
      if (k > 0) @(negedge clk_in);
      s = k / 7;
      p = k % 7;
      if (p == 0) begin
        color = 24'h000000;
        for (int i = 0; i < NV; i++)
          if (vecs[i].y * HT + vecs[i].x == s) color = vecs[i].color;
        check($sformatf("x slot %0d", s),   32'(x),   32'(s % HT));
        check($sformatf("y slot %0d", s),   32'(y),   32'((s / HT) % VT));
        check($sformatf("led slot %0d", s), 32'(led), 32'((s / (HT * VT)) % 256));
      end
      cap0[6-p] = rx[0];
      cap1[6-p] = rx[1];
      cap2[6-p] = rx[2];
      if (s == 0) begin
        check($sformatf("rx idle ph %0d", p),      32'(rx),      32'd0);
        check($sformatf("clk_out idle ph %0d", p), 32'(clk_out), 32'd0);
      end else begin
        check($sformatf("clk_out slot %0d ph %0d", s, p), 32'(clk_out), 32'(clk_exp[6-p]));
      end
      if (p == 6 && s >= 1) begin
        for (int i = 0; i < NV; i++) begin
          if (vecs[i].y * HT + vecs[i].x == s - 1) begin
            check($sformatf("lane0 (%0d,%0d)", vecs[i].x, vecs[i].y), 32'(cap0), 32'(vecs[i].l0));
            check($sformatf("lane1 (%0d,%0d)", vecs[i].x, vecs[i].y), 32'(cap1), 32'(vecs[i].l1));
            check($sformatf("lane2 (%0d,%0d)", vecs[i].x, vecs[i].y), 32'(cap2), 32'(vecs[i].l2));
          end
        end
      end
    end
  endtask

  initial begin
    clk_exp = 7'b1100011;
    // {x, y, color, lane0, lane1, lane2}; HS low for x in [10,12), VS low on y == 5
    vecs[0]  = '{0,  0, 24'hFC0000, 7'b0111111, 7'b0000000, 7'b1110000};
    vecs[1]  = '{1,  0, 24'h00FC00, 7'b1000000, 7'b0011111, 7'b1110000};
    vecs[2]  = '{2,  0, 24'h0000FC, 7'b0000000, 7'b1100000, 7'b1111111};
    vecs[3]  = '{3,  0, 24'h123456, 7'b1000100, 7'b0100110, 7'b1110101};
    vecs[4]  = '{8,  0, 24'hFFFFFF, 7'b0000000, 7'b0000000, 7'b0110000};
    vecs[5]  = '{10, 0, 24'hFFFFFF, 7'b0000000, 7'b0000000, 7'b0100000};
    vecs[6]  = '{11, 0, 24'hFFFFFF, 7'b0000000, 7'b0000000, 7'b0100000};
    vecs[7]  = '{12, 0, 24'hFFFFFF, 7'b0000000, 7'b0000000, 7'b0110000};
    vecs[8]  = '{7,  3, 24'hFFFFFF, 7'b1111111, 7'b1111111, 7'b1111111};
    vecs[9]  = '{0,  4, 24'hFFFFFF, 7'b0000000, 7'b0000000, 7'b0110000};
    vecs[10] = '{0,  5, 24'hFFFFFF, 7'b0000000, 7'b0000000, 7'b0010000};
    vecs[11] = '{10, 5, 24'hFFFFFF, 7'b0000000, 7'b0000000, 7'b0000000};
    vecs[12] = '{0,  6, 24'hFFFFFF, 7'b0000000, 7'b0000000, 7'b0110000};
    vecs[13] = '{13, 6, 24'hFFFFFF, 7'b0000000, 7'b0000000, 7'b0110000};

    button = 1'b0;
    color  = 24'h000000;

    // Held in reset: everything stays at its reset value
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_in);
      check_reset_state($sformatf("hold %0d", i));
    end

    // Release and run a full frame plus part of the next, stopping at (5,2)
    button = 1'b1;
    run((HT * VT + 2 * HT + 5) * 7 + 3);
    check("mid-frame x before reset",   32'(x),   32'd5);
    check("mid-frame y before reset",   32'(y),   32'd2);
    check("mid-frame led before reset", 32'(led), 32'd1);

    // Asynchronous reset mid-slot takes effect without a clock edge
    button = 1'b0;
    #1;
    check_reset_state("async reset");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_in);
      check_reset_state($sformatf("reheld %0d", i));
    end

    // Restart from (0,0) and re-check the first few slots
    button = 1'b1;
    run(4 * 7 + 6);

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
